// File: rtl/lm32_sim_ctrl_pkg.sv
// Shared definitions for the LM32 simulation-control slave: register offsets,
// bus FSM encoding and STATUS word layout.
package lm32_sim_ctrl_pkg;

  // Word offsets decoded from wb_adr[3:2].
  typedef enum logic [1:0] {
    RegExit    = 2'd0,
    RegConsole = 2'd1,
    RegStatus  = 2'd2,
    RegCycle   = 2'd3
  } reg_addr_e;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StResp     = 2'd1,
    StWaitFull = 2'd2
  } bus_state_e;

  // STATUS bit positions.
  localparam int unsigned StatusEmptyBit  = 0;
  localparam int unsigned StatusFullBit   = 1;
  localparam int unsigned StatusExitedBit = 2;
  localparam int unsigned StatusCountLsb  = 8;

  function automatic logic [31:0] status_word(input logic [7:0] count, input logic exited,
                                               input logic full, input logic empty);
    logic [31:0] w;
    w = '0;
    w[StatusEmptyBit]              = empty;
    w[StatusFullBit]               = full;
    w[StatusExitedBit]             = exited;
    w[StatusCountLsb +: 8]         = count;
    return w;
  endfunction

endpackage

// File: rtl/lm32_sim_ctrl_if.sv
// Wishbone classic bus bundle between the LM32 and the simulation-control slave.
interface lm32_sim_ctrl_if;
  logic [3:0]  wb_adr;
  logic [31:0] wb_dat_w;
  logic [31:0] wb_dat_r;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_ack;
  logic        wb_err;

  modport master (
    output wb_adr, wb_dat_w, wb_sel, wb_we, wb_cyc, wb_stb,
    input  wb_dat_r, wb_ack, wb_err
  );

  modport slave (
    input  wb_adr, wb_dat_w, wb_sel, wb_we, wb_cyc, wb_stb,
    output wb_dat_r, wb_ack, wb_err
  );
endinterface

// File: rtl/lm32_sim_fifo.sv
// First-word fall-through FIFO for console bytes. Push while full is only
// honoured when a pop happens in the same cycle.
module lm32_sim_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16,
  localparam int unsigned AddrW = $clog2(Depth),
  localparam int unsigned CntW  = AddrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  // Head shown with no latency; forced to zero when empty so reset leaves it clean.
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Storage array, no reset needed.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/lm32_sim_ctrl.sv
// Wishbone slave that lets LM32 firmware end a simulation (EXIT register) and
// stream console bytes out through a FIFO. Read-only writes and stalled console
// writes terminate with err.
module lm32_sim_ctrl
  import lm32_sim_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned TX_TIMEOUT = 1024
) (
  input  logic           clk_i,
  input  logic           rst_i,
  lm32_sim_ctrl_if.slave wb,
  output logic           exit_valid_o,
  output logic [31:0]    exit_code_o,
  output logic [7:0]     char_o,
  output logic           char_valid_o,
  input  logic           char_ready_i
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TmoW = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;

  bus_state_e      state_q, state_d;
  logic            resp_err_q, resp_err_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            exit_valid_q, exit_valid_d;
  logic [31:0]     exit_code_q, exit_code_d;
  logic            exited_q, exited_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [31:0]     cycle_q;

  logic            req;
  reg_addr_e       reg_sel;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;
  logic            unused_bits;

  assign req         = wb.wb_cyc && wb.wb_stb;
  assign reg_sel     = reg_addr_e'(wb.wb_adr[3:2]);
  assign fifo_pop    = char_valid_o && char_ready_i;
  assign unused_bits = ^{wb.wb_adr[1:0], wb.wb_sel};

  lm32_sim_fifo #(
    .Width (8),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (wb.wb_dat_w[7:0]),
    .pop_i   (fifo_pop),
    .data_o  (char_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign char_valid_o = !fifo_empty;
  assign exit_valid_o = exit_valid_q;
  assign exit_code_o  = exit_code_q;
  // Termination is masked if the master drops the request mid-response.
  assign wb.wb_ack    = (state_q == StResp) && !resp_err_q && req;
  assign wb.wb_err    = (state_q == StResp) && resp_err_q && req;
  assign wb.wb_dat_r  = rdata_q;

  // Bus FSM next state, register side effects and FIFO push decision.
  always_comb begin
    state_d      = state_q;
    resp_err_d   = resp_err_q;
    rdata_d      = rdata_q;
    exit_valid_d = 1'b0;
    exit_code_d  = exit_code_q;
    exited_d     = exited_q;
    tmo_d        = tmo_q;
    fifo_push    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d    = StResp;
          resp_err_d = 1'b0;
          rdata_d    = '0;
          unique case (reg_sel)
            RegExit: begin
              if (wb.wb_we) begin
                exit_code_d  = wb.wb_dat_w;
                exited_d     = 1'b1;
                exit_valid_d = 1'b1;
              end else begin
                rdata_d = exit_code_q;
              end
            end
            RegConsole: begin
              if (wb.wb_we) begin
                if (fifo_full) begin
                  state_d = StWaitFull;
                  tmo_d   = TmoW'(TX_TIMEOUT - 1);
                end else begin
                  fifo_push = 1'b1;
                end
              end
            end
            RegStatus: begin
              if (wb.wb_we) resp_err_d = 1'b1;
              else rdata_d = status_word(8'(fifo_count), exited_q, fifo_full, fifo_empty);
            end
            RegCycle: begin
              if (wb.wb_we) resp_err_d = 1'b1;
              else rdata_d = cycle_q;
            end
          endcase
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      StWaitFull: begin
        if (!req) begin
          state_d = StIdle;
        end else if (!fifo_full || fifo_pop) begin
          // A pop in this cycle frees the slot we push into.
          fifo_push  = 1'b1;
          state_d    = StResp;
          resp_err_d = 1'b0;
        end else if (tmo_q == '0) begin
          state_d    = StResp;
          resp_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q - TmoW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Registered state; synchronous reset abandons any transfer in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      resp_err_q   <= 1'b0;
      rdata_q      <= '0;
      exit_valid_q <= 1'b0;
      exit_code_q  <= '0;
      exited_q     <= 1'b0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      resp_err_q   <= resp_err_d;
      rdata_q      <= rdata_d;
      exit_valid_q <= exit_valid_d;
      exit_code_q  <= exit_code_d;
      exited_q     <= exited_d;
      tmo_q        <= tmo_d;
    end
  end

  // Free-running cycle counter, wraps modulo 2^32.
  always_ff @(posedge clk_i) begin
    if (rst_i) cycle_q <= '0;
    else       cycle_q <= cycle_q + 32'd1;
  end

endmodule

// File: tb/tb_lm32_sim_ctrl.sv
// Self-checking bench for lm32_sim_ctrl: directed scenarios plus a randomized
// operation mix, checked against a queue-based model of the register map.
module tb_lm32_sim_ctrl;

  localparam int unsigned Depth   = 16;
  localparam int unsigned Timeout = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        exit_valid;
  logic [31:0] exit_code;
  logic [7:0]  ch;
  logic        ch_valid;
  logic        ch_ready;

  lm32_sim_ctrl_if wb ();

  lm32_sim_ctrl #(
    .FIFO_DEPTH (Depth),
    .TX_TIMEOUT (Timeout)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .wb           (wb),
    .exit_valid_o (exit_valid),
    .exit_code_o  (exit_code),
    .char_o       (ch),
    .char_valid_o (ch_valid),
    .char_ready_i (ch_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_cnt = 0;

  // Reference model state.
  logic [7:0]  q[$];
  logic [31:0] m_exit_code = '0;
  logic        m_exited = 1'b0;
  logic        chk_valid = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    return {16'b0, 8'(q.size()), 5'b0, m_exited, q.size() == Depth, q.size() == 0};
  endfunction

  // Consumer side: every accepted byte must be the oldest byte the model holds.
  always @(negedge clk) begin
    if (!rst) begin
      if (chk_valid) check_eq("char_valid", {31'b0, ch_valid}, {31'b0, q.size() != 0});
      if (ch_valid && ch_ready) begin
        if (q.size() == 0) begin
          check_eq("pop_on_empty", {31'b0, ch_valid}, 32'd0);
        end else begin
          check_eq("char", {24'b0, ch}, {24'b0, q[0]});
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic wb_xfer(input logic we, input logic [1:0] ri, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic ack, output logic err,
                         output int lat, output logic exv, output logic exv_after,
                         output int req_edge);
    wb.wb_adr   = {ri, 2'($urandom)};
    wb.wb_sel   = 4'($urandom);
    wb.wb_we    = we;
    wb.wb_dat_w = wdata;
    wb.wb_cyc   = 1'b1;
    wb.wb_stb   = 1'b1;
    lat = 0; ack = 1'b0; err = 1'b0; rdata = '0; exv = 1'b0; req_edge = 0;
    while (!(ack || err) && lat < int'(Timeout) + 20) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) req_edge = edge_cnt;
      ack   = wb.wb_ack;
      err   = wb.wb_err;
      rdata = wb.wb_dat_r;
      exv   = exit_valid;
    end
    if (!(ack || err)) check_eq("xfer_bound", lat, 32'd0);
    if (ack && we && ri == 2'd1) q.push_back(wdata[7:0]);
    if (ack && we && ri == 2'd0) begin
      m_exit_code = wdata;
      m_exited    = 1'b1;
    end
    wb.wb_cyc = 1'b0;
    wb.wb_stb = 1'b0;
    wb.wb_we  = 1'b0;
    @(posedge clk); #1;
    exv_after = exit_valid;
  endtask

  task automatic bus_check(input string tag, input logic we, input logic [1:0] ri,
                           input logic [31:0] wdata, input logic exp_ack, input int exp_lat,
                           input logic chk_rd, input logic [31:0] exp_rd,
                           output logic [31:0] rdata, output int req_edge);
    logic ack, err, exv, exv_after;
    int   lat;
    wb_xfer(we, ri, wdata, rdata, ack, err, lat, exv, exv_after, req_edge);
    check_eq({tag, ".ack"}, {31'b0, ack}, {31'b0, exp_ack});
    check_eq({tag, ".err"}, {31'b0, err}, {31'b0, !exp_ack});
    check_eq({tag, ".lat"}, lat, exp_lat);
    if (chk_rd) check_eq({tag, ".rdata"}, rdata, exp_rd);
    check_eq({tag, ".exv"}, {31'b0, exv}, {31'b0, we && ri == 2'd0 && exp_ack});
    check_eq({tag, ".exv_after"}, {31'b0, exv_after}, 32'd0);
    check_eq({tag, ".code"}, exit_code, m_exit_code);
  endtask

  task automatic fill_fifo();
    logic [31:0] rd;
    int          e;
    while (q.size() < Depth) bus_check("fill", 1'b1, 2'd1, $urandom, 1'b1, 1, 1'b0, '0, rd, e);
  endtask

  task automatic drain_all();
    chk_valid = 1'b1;
    ch_ready  = 1'b1;
    repeat (Depth + 1) @(posedge clk);
    #1;
    check_eq("drained", {31'b0, ch_valid}, 32'd0);
    ch_ready = 1'b0;
    @(posedge clk); #1;
    chk_valid = 1'b0;
  endtask

  task automatic drain_random(input int n);
    chk_valid = 1'b1;
    repeat (n) begin
      ch_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    ch_ready = 1'b0;
    @(posedge clk); #1;
    chk_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, r1, r2, b17, code;
    logic        a17, er17, x1, x2;
    int          e, e1, e2, l17;

    rst = 1'b1; ch_ready = 1'b0;
    wb.wb_adr = '0; wb.wb_dat_w = '0; wb.wb_sel = '0;
    wb.wb_we = 1'b0; wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst.ack", {31'b0, wb.wb_ack}, 32'd0);
    check_eq("rst.err", {31'b0, wb.wb_err}, 32'd0);
    check_eq("rst.dat", wb.wb_dat_r, 32'd0);
    check_eq("rst.exv", {31'b0, exit_valid}, 32'd0);
    check_eq("rst.code", exit_code, 32'd0);
    check_eq("rst.char", {24'b0, ch}, 32'd0);
    check_eq("rst.cvalid", {31'b0, ch_valid}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // EXIT write then STATUS.
    bus_check("exit", 1'b1, 2'd0, 32'h2A, 1'b1, 1, 1'b0, '0, rd, e);
    bus_check("stat1", 1'b0, 2'd2, '0, 1'b1, 1, 1'b1, 32'h5, rd, e);
    bus_check("exit_rd", 1'b0, 2'd0, '0, 1'b1, 1, 1'b1, 32'h2A, rd, e);

    // Three console bytes held, then released on consecutive cycles.
    bus_check("con_a", 1'b1, 2'd1, 32'h41, 1'b1, 1, 1'b0, '0, rd, e);
    bus_check("con_b", 1'b1, 2'd1, 32'h42, 1'b1, 1, 1'b0, '0, rd, e);
    bus_check("con_c", 1'b1, 2'd1, 32'h43, 1'b1, 1, 1'b0, '0, rd, e);
    bus_check("stat3", 1'b0, 2'd2, '0, 1'b1, 1, 1'b1, exp_status(), rd, e);
    chk_valid = 1'b1;
    ch_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("abc_empty", {31'b0, ch_valid}, 32'd0);
    ch_ready = 1'b0;
    @(posedge clk); #1;
    chk_valid = 1'b0;

    // 17th write stalls until a single pop frees a slot.
    fill_fifo();
    bus_check("stat_full", 1'b0, 2'd2, '0, 1'b1, 1, 1'b1, exp_status(), rd, e);
    b17 = $urandom;
    fork
      wb_xfer(1'b1, 2'd1, b17, rd, a17, er17, l17, x1, x2, e);
      begin
        repeat (50) @(posedge clk);
        #1 ch_ready = 1'b1;
        @(posedge clk);
        #1 ch_ready = 1'b0;
      end
    join
    check_eq("w17.ack", {31'b0, a17}, 32'd1);
    check_eq("w17.err", {31'b0, er17}, 32'd0);
    check_eq("w17.lat_in_window", {31'b0, l17 >= 51 && l17 <= 52}, 32'd1);
    bus_check("stat17", 1'b0, 2'd2, '0, 1'b1, 1, 1'b1, exp_status(), rd, e);
    drain_all();

    // Timeout on a full FIFO: err, byte dropped.
    fill_fifo();
    bus_check("tmo", 1'b1, 2'd1, 32'h5A, 1'b0, int'(Timeout) + 1, 1'b0, '0, rd, e);
    bus_check("stat_tmo", 1'b0, 2'd2, '0, 1'b1, 1, 1'b1, exp_status(), rd, e);
    drain_all();

    // Writes to read-only registers, then cycle counter delta.
    bus_check("wr_stat", 1'b1, 2'd2, $urandom, 1'b0, 1, 1'b0, '0, rd, e);
    bus_check("wr_cyc", 1'b1, 2'd3, $urandom, 1'b0, 1, 1'b0, '0, rd, e);
    bus_check("stat_ro", 1'b0, 2'd2, '0, 1'b1, 1, 1'b1, exp_status(), rd, e);
    bus_check("cyc1", 1'b0, 2'd3, '0, 1'b1, 1, 1'b0, '0, r1, e1);
    repeat ($urandom_range(0, 30)) @(posedge clk);
    #1;
    bus_check("cyc2", 1'b0, 2'd3, '0, 1'b1, 1, 1'b0, '0, r2, e2);
    check_eq("cycle_delta", r2 - r1, e2 - e1);

    // Reset while stalled on a full FIFO.
    fill_fifo();
    wb.wb_adr = 4'h4; wb.wb_dat_w = 32'h77; wb.wb_we = 1'b1;
    wb.wb_cyc = 1'b1; wb.wb_stb = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_wf.ack", {31'b0, wb.wb_ack}, 32'd0);
    check_eq("rst_wf.err", {31'b0, wb.wb_err}, 32'd0);
    check_eq("rst_wf.cvalid", {31'b0, ch_valid}, 32'd0);
    rst = 1'b0; wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0; wb.wb_we = 1'b0;
    q.delete(); m_exited = 1'b0; m_exit_code = '0;
    @(posedge clk); #1;
    bus_check("stat_rst1", 1'b0, 2'd2, '0, 1'b1, 1, 1'b1, 32'h1, rd, e);

    // Reset while an EXIT response is on the bus.
    wb.wb_adr = 4'h0; wb.wb_dat_w = 32'hDEAD; wb.wb_we = 1'b1;
    wb.wb_cyc = 1'b1; wb.wb_stb = 1'b1;
    @(posedge clk); #1;
    check_eq("rsp.ack_before", {31'b0, wb.wb_ack}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_rsp.ack", {31'b0, wb.wb_ack}, 32'd0);
    check_eq("rst_rsp.err", {31'b0, wb.wb_err}, 32'd0);
    check_eq("rst_rsp.code", exit_code, 32'd0);
    check_eq("rst_rsp.exv", {31'b0, exit_valid}, 32'd0);
    rst = 1'b0; wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0; wb.wb_we = 1'b0;
    @(posedge clk); #1;
    bus_check("stat_rst2", 1'b0, 2'd2, '0, 1'b1, 1, 1'b1, 32'h1, rd, e);
    bus_check("exit_again", 1'b1, 2'd0, 32'h1234, 1'b1, 1, 1'b0, '0, rd, e);
    bus_check("stat_rst3", 1'b0, 2'd2, '0, 1'b1, 1, 1'b1, 32'h5, rd, e);

    // Randomized mix.
    for (int i = 0; i < 300; i++) begin
      int op;
      op = int'($urandom_range(0, 6));
      case (op)
        0: begin
          code = $urandom;
          bus_check("r_exitw", 1'b1, 2'd0, code, 1'b1, 1, 1'b0, '0, rd, e);
        end
        1: begin
          if (q.size() < Depth) bus_check("r_con", 1'b1, 2'd1, $urandom, 1'b1, 1, 1'b0, '0, rd, e);
          else drain_random(int'($urandom_range(1, 20)));
        end
        2: bus_check("r_stat", 1'b0, 2'd2, $urandom, 1'b1, 1, 1'b1, exp_status(), rd, e);
        3: bus_check("r_exitr", 1'b0, 2'd0, $urandom, 1'b1, 1, 1'b1, m_exit_code, rd, e);
        4: bus_check("r_rowr", 1'b1, 2'($urandom_range(2, 3)), $urandom, 1'b0, 1, 1'b0, '0,
                     rd, e);
        5: bus_check("r_conrd", 1'b0, 2'd1, $urandom, 1'b1, 1, 1'b1, 32'd0, rd, e);
        default: drain_random(int'($urandom_range(1, 20)));
      endcase
    end
    drain_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
